// File: rtl/icache_fetch_ctrl.sv
// Fetch-side icache controller: sequential line requests, in-flight tracking, FWFT line buffer, flush with stale-drop.
// Define FETCH_CTRL_PERF_EN to add saturating perf_req_o / perf_drop_o counters.
package icache_fetch_pkg;
   localparam int XLEN         = 32;
   localparam int ICACHE_INSTR = 4;

   typedef struct packed {
      logic [XLEN-1:0]               pc;
      logic [ICACHE_INSTR-1:0][31:0] line;
   } icache_out_t;
endpackage

module icache_fetch_ctrl
   import icache_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] BOOT_PC    = 32'h0000_0000,
   parameter int              MAX_OUT    = 2,
   parameter int              LINE_BYTES = ICACHE_INSTR * 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] flush_pc_i,
   output logic [XLEN-1:0] icache_addr_o,
   output logic            icache_addr_valid_o,
   input  logic            icache_addr_ready_i,
   input  icache_out_t     icache_data_i,
   input  logic            icache_data_valid_i,
   output logic            icache_data_ready_o,
   output icache_out_t     fetch_data_o,
   output logic            fetch_valid_o,
   input  logic            fetch_ready_i
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [31:0]     perf_req_o,
   output logic [31:0]     perf_drop_o
`endif
);

   localparam int CW = $clog2(MAX_OUT + 1);
   localparam int SW = CW + 2;
   localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(LINE_BYTES - 1));

   function automatic logic [XLEN-1:0] align_line(input logic [XLEN-1:0] a);
      return a & ALIGN_MASK;
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   logic            active;
   logic [XLEN-1:0] pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   fifo_count;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   icache_out_t     mem [MAX_OUT];

   logic [SW-1:0]   in_use;
   logic            addr_hs;
   logic            rsp;
   logic            rsp_drop;
   logic            rsp_keep;
   logic            rsp_err;
   logic            push;
   logic            pop;

   // Every slot (in flight, awaiting drop, or buffered) is reserved at issue,
   // so an accepted response always has room in the buffer.
   assign in_use              = SW'(outstanding) + SW'(drop_cnt) + SW'(fifo_count);
   assign icache_addr_valid_o = active & ~flush_i & (in_use < SW'(MAX_OUT));
   assign icache_addr_o       = pc;
   assign icache_data_ready_o = active;

   assign addr_hs  = icache_addr_valid_o & icache_addr_ready_i;
   assign rsp      = icache_data_valid_i & icache_data_ready_o;
   assign rsp_drop = rsp & (drop_cnt != '0);
   assign rsp_keep = rsp & (drop_cnt == '0) & (outstanding != '0);
   assign rsp_err  = rsp & (drop_cnt == '0) & (outstanding == '0);

   assign fetch_valid_o = (fifo_count != '0);
   assign fetch_data_o  = fetch_valid_o ? mem[rd_ptr] : '0;
   assign push          = rsp_keep & ~flush_i;
   assign pop           = fetch_valid_o & fetch_ready_i & ~flush_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         active      <= 1'b0;
         pc          <= align_line(BOOT_PC);
         outstanding <= '0;
         drop_cnt    <= '0;
         fifo_count  <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         active <= 1'b1;
         if (flush_i) begin
            // Everything issued so far, minus the line consumed this cycle, becomes stale.
            pc          <= align_line(flush_pc_i);
            drop_cnt    <= CW'(SW'(drop_cnt) + SW'(outstanding) + SW'(addr_hs)
                               - SW'(rsp_drop | rsp_keep));
            outstanding <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
         end else begin
            if (addr_hs) pc <= pc + XLEN'(LINE_BYTES);
            outstanding <= outstanding + CW'(addr_hs) - CW'(rsp_keep);
            drop_cnt    <= drop_cnt - CW'(rsp_drop);
            fifo_count  <= fifo_count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= icache_data_i;
   end

`ifdef FETCH_CTRL_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_req_o  <= '0;
         perf_drop_o <= '0;
      end else begin
         if (addr_hs)             perf_req_o  <= sat_inc(perf_req_o);
         if (rsp_drop | rsp_err)  perf_drop_o <= sat_inc(perf_drop_o);
      end
   end
`endif

`ifndef SYNTHESIS
   a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (rst_i) !rsp_err);
   a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      (outstanding <= CW'(MAX_OUT)) && (drop_cnt <= CW'(MAX_OUT)) &&
      (fifo_count <= CW'(MAX_OUT)) && (in_use <= SW'(MAX_OUT)));
`endif

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed bench for icache_fetch_ctrl with a fixed-latency icache model and hand-computed expectations.
module tb_icache_fetch_ctrl;
   import icache_fetch_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic [31:0] flush_pc_i = '0;
   logic [31:0] icache_addr_o;
   logic        icache_addr_valid_o;
   logic        icache_addr_ready_i = 1'b0;
   icache_out_t icache_data_i = '0;
   logic        icache_data_valid_i = 1'b0;
   logic        icache_data_ready_o;
   icache_out_t fetch_data_o;
   logic        fetch_valid_o;
   logic        fetch_ready_i = 1'b0;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] perf_req_o;
   logic [31:0] perf_drop_o;
`endif

   icache_fetch_ctrl #(.BOOT_PC(32'h100), .MAX_OUT(2), .LINE_BYTES(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
      .icache_addr_o(icache_addr_o), .icache_addr_valid_o(icache_addr_valid_o),
      .icache_addr_ready_i(icache_addr_ready_i), .icache_data_i(icache_data_i),
      .icache_data_valid_i(icache_data_valid_i), .icache_data_ready_o(icache_data_ready_o),
      .fetch_data_o(fetch_data_o), .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready_i)
`ifdef FETCH_CTRL_PERF_EN
      , .perf_req_o(perf_req_o), .perf_drop_o(perf_drop_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic [31:0] addr; int due; } req_t;
   req_t        pend[$];
   logic [31:0] issued[$];
   logic [31:0] fetched[$];
   logic [31:0] fetched_w[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          lat = 1;
   logic        rdy = 1'b1;
   logic        flush_req = 1'b0;
   logic [31:0] flush_pc_req = '0;
   logic        s_valid;

   // One clock: drive inputs after the edge, sample mid-cycle, advance to just past the next edge.
   task automatic tick();
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         icache_data_valid_i = 1'b1;
         icache_data_i.pc = pend[0].addr;
         for (int k = 0; k < ICACHE_INSTR; k++)
            icache_data_i.line[k] = pend[0].addr ^ (32'h1111_0000 * 32'(k));
      end else begin
         icache_data_valid_i = 1'b0;
         icache_data_i = '0;
      end
      flush_i = flush_req;
      flush_pc_i = flush_pc_req;
      fetch_ready_i = rdy;
      icache_addr_ready_i = 1'b1;
      #1;
      s_valid = icache_addr_valid_o;
      if (icache_data_valid_i && icache_data_ready_o) void'(pend.pop_front());
      if (icache_addr_valid_o && icache_addr_ready_i) begin
         issued.push_back(icache_addr_o);
         pend.push_back('{addr: icache_addr_o, due: cyc + lat});
      end
      if (fetch_valid_o && fetch_ready_i && !flush_i) begin
         fetched.push_back(fetch_data_o.pc);
         fetched_w.push_back(fetch_data_o.line[2]);
      end
      @(posedge clk_i); #1;
      cyc++;
      flush_req = 1'b0;
      flush_i = 1'b0;
   endtask

   task automatic clear_model();
      pend.delete(); issued.delete(); fetched.delete(); fetched_w.delete();
      cyc = 0; flush_req = 1'b0; flush_i = 1'b0;
      icache_data_valid_i = 1'b0; icache_data_i = '0;
   endtask

   task automatic apply_reset();
      rst_i = 1'b1;
      clear_model();
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset();
      clear_model();
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      checks++; if (icache_addr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_addr_valid: got %b expected 0", icache_addr_valid_o); end
      checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid: got %b expected 0", fetch_valid_o); end
      checks++; if (fetch_data_o !== '0) begin errors++; $display("FAIL reset_fetch_data: got %h expected 0", fetch_data_o); end
      checks++; if (icache_data_ready_o !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %b expected 0", icache_data_ready_o); end
      checks++; if (icache_addr_o !== 32'h100) begin errors++; $display("FAIL reset_addr: got %h expected 00000100", icache_addr_o); end
      rst_i = 1'b0;
      #1;
      checks++; if (icache_addr_valid_o !== 1'b0) begin errors++; $display("FAIL pre_edge_addr_valid: got %b expected 0", icache_addr_valid_o); end
      @(posedge clk_i); #1;
      checks++; if (icache_addr_valid_o !== 1'b1) begin errors++; $display("FAIL first_edge_addr_valid: got %b expected 1", icache_addr_valid_o); end
      checks++; if (icache_data_ready_o !== 1'b1) begin errors++; $display("FAIL first_edge_data_ready: got %b expected 1", icache_data_ready_o); end
   endtask

   task automatic test_stream();
      apply_reset();
      lat = 1; rdy = 1'b1;
      for (int i = 0; i < 60 && fetched.size() < 4; i++) tick();
      checks++; if (fetched.size() < 4) begin errors++; $display("FAIL stream_timeout: got %0d lines expected 4", fetched.size()); end
      checks++; if (issued[3] !== 32'h130) begin errors++; $display("FAIL stream_addr3: got %h expected 00000130", issued[3]); end
      checks++; if (fetched[0] !== 32'h100) begin errors++; $display("FAIL stream_pc0: got %h expected 00000100", fetched[0]); end
      checks++; if (fetched[1] !== 32'h110) begin errors++; $display("FAIL stream_pc1: got %h expected 00000110", fetched[1]); end
      checks++; if (fetched[3] !== 32'h130) begin errors++; $display("FAIL stream_pc3: got %h expected 00000130", fetched[3]); end
      checks++; if (fetched_w[2] !== 32'h2222_0120) begin errors++; $display("FAIL stream_word: got %h expected 22220120", fetched_w[2]); end
   endtask

   task automatic test_backpressure();
      apply_reset();
      lat = 1; rdy = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      checks++; if (issued.size() != 2) begin errors++; $display("FAIL bp_issue_count: got %0d expected 2", issued.size()); end
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL bp_addr_valid: got %b expected 0", s_valid); end
      checks++; if (fetch_valid_o !== 1'b1 || fetch_data_o.pc !== 32'h100) begin errors++; $display("FAIL bp_head: got %b/%h expected 1/00000100", fetch_valid_o, fetch_data_o.pc); end
      rdy = 1'b1;
      for (int i = 0; i < 60 && fetched.size() < 4; i++) tick();
      checks++; if (fetched.size() < 4) begin errors++; $display("FAIL bp_timeout: got %0d lines expected 4", fetched.size()); end
      checks++; if (fetched[0] !== 32'h100 || fetched[1] !== 32'h110 || fetched[2] !== 32'h120) begin errors++; $display("FAIL bp_order: got %h %h %h expected 00000100 00000110 00000120", fetched[0], fetched[1], fetched[2]); end
      checks++; if (issued[2] !== 32'h120) begin errors++; $display("FAIL bp_resume: got %h expected 00000120", issued[2]); end
   endtask

   task automatic test_flush_inflight();
      apply_reset();
      lat = 3; rdy = 1'b1;
      tick(); tick();
      flush_req = 1'b1; flush_pc_req = 32'h204;
      tick();
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_forced: got %b expected 0", s_valid); end
      checks++; if (icache_addr_o !== 32'h200) begin errors++; $display("FAIL flush_pc_align: got %h expected 00000200", icache_addr_o); end
      for (int i = 0; i < 60 && fetched.size() < 2; i++) tick();
      checks++; if (fetched.size() < 2) begin errors++; $display("FAIL flush_timeout: got %0d lines expected 2", fetched.size()); end
      checks++; if (fetched[0] !== 32'h200 || fetched[1] !== 32'h210) begin errors++; $display("FAIL flush_lines: got %h %h expected 00000200 00000210", fetched[0], fetched[1]); end
      checks++; if (issued[2] !== 32'h200) begin errors++; $display("FAIL flush_reissue: got %h expected 00000200", issued[2]); end
`ifdef FETCH_CTRL_PERF_EN
      checks++; if (perf_drop_o !== 32'd2) begin errors++; $display("FAIL perf_drop: got %0d expected 2", perf_drop_o); end
`endif
   endtask

   task automatic test_back_to_back();
      apply_reset();
      lat = 3; rdy = 1'b1;
      tick(); tick();
      flush_req = 1'b1; flush_pc_req = 32'h500;
      tick();
      flush_req = 1'b1; flush_pc_req = 32'h204;
      tick();
      for (int i = 0; i < 60 && fetched.size() < 2; i++) tick();
      checks++; if (fetched.size() < 2) begin errors++; $display("FAIL b2b_timeout: got %0d lines expected 2", fetched.size()); end
      checks++; if (issued[2] !== 32'h200) begin errors++; $display("FAIL b2b_reissue: got %h expected 00000200", issued[2]); end
      checks++; if (fetched[0] !== 32'h200 || fetched[1] !== 32'h210) begin errors++; $display("FAIL b2b_lines: got %h %h expected 00000200 00000210", fetched[0], fetched[1]); end
   endtask

   task automatic test_flush_collide();
      apply_reset();
      lat = 1; rdy = 1'b1;
      tick();
      flush_req = 1'b1; flush_pc_req = 32'h300;
      tick();
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL collide_valid_forced: got %b expected 0", s_valid); end
      checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL collide_no_stale: got %b expected 0", fetch_valid_o); end
      for (int i = 0; i < 60 && fetched.size() < 2; i++) tick();
      checks++; if (fetched.size() < 2) begin errors++; $display("FAIL collide_timeout: got %0d lines expected 2", fetched.size()); end
      checks++; if (fetched[0] !== 32'h300 || fetched[1] !== 32'h310) begin errors++; $display("FAIL collide_lines: got %h %h expected 00000300 00000310", fetched[0], fetched[1]); end
   endtask

   task automatic test_wrap();
      apply_reset();
      lat = 1; rdy = 1'b1;
      flush_req = 1'b1; flush_pc_req = 32'hFFFF_FFF8;
      tick();
      checks++; if (icache_addr_o !== 32'hFFFF_FFF0) begin errors++; $display("FAIL wrap_align: got %h expected fffffff0", icache_addr_o); end
      for (int i = 0; i < 60 && fetched.size() < 2; i++) tick();
      checks++; if (fetched.size() < 2) begin errors++; $display("FAIL wrap_timeout: got %0d lines expected 2", fetched.size()); end
      checks++; if (issued[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 00000000", issued[1]); end
      checks++; if (fetched[0] !== 32'hFFFF_FFF0 || fetched[1] !== 32'h0) begin errors++; $display("FAIL wrap_lines: got %h %h expected fffffff0 00000000", fetched[0], fetched[1]); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      lat = 1; rdy = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checks++; if (fetch_valid_o !== 1'b1 || fetch_data_o.pc !== 32'h100) begin errors++; $display("FAIL rmid_pre_full: got %b/%h expected 1/00000100", fetch_valid_o, fetch_data_o.pc); end
      #2 rst_i = 1'b1;
      #1;
      checks++; if (fetch_valid_o !== 1'b0 || fetch_data_o !== '0) begin errors++; $display("FAIL rmid_fetch: got %b/%h expected 0/0", fetch_valid_o, fetch_data_o); end
      checks++; if (icache_addr_valid_o !== 1'b0 || icache_data_ready_o !== 1'b0) begin errors++; $display("FAIL rmid_handshake: got %b/%b expected 0/0", icache_addr_valid_o, icache_data_ready_o); end
      checks++; if (icache_addr_o !== 32'h100) begin errors++; $display("FAIL rmid_addr: got %h expected 00000100", icache_addr_o); end
      @(posedge clk_i); #1;
      clear_model();
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      rdy = 1'b1;
      for (int i = 0; i < 60 && fetched.size() < 2; i++) tick();
      checks++; if (fetched.size() < 2) begin errors++; $display("FAIL rmid_timeout: got %0d lines expected 2", fetched.size()); end
      checks++; if (fetched[0] !== 32'h100 || fetched[1] !== 32'h110) begin errors++; $display("FAIL rmid_restart: got %h %h expected 00000100 00000110", fetched[0], fetched[1]); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush_inflight();
      test_back_to_back();
      test_flush_collide();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
